// File: rtl/laplace_pkg.sv
// Shared types and constants for the Laplacian scan controller and its address generator.
package laplace_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LAST  = 3'd2,
    CALC  = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DEF_IMG_W  = 512;
  localparam int DEF_IMG_H  = 512;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_CRD_W  = 9;

  // Read order of the cross neighbourhood: north, west, centre, east, south.
  localparam logic [2:0] K_B = 3'd0;
  localparam logic [2:0] K_D = 3'd1;
  localparam logic [2:0] K_E = 3'd2;
  localparam logic [2:0] K_F = 3'd3;
  localparam logic [2:0] K_H = 3'd4;

endpackage

// File: rtl/laplace_addr_gen.sv
// Combinational read address for neighbour k of the window whose top-left corner is (row, col).
module laplace_addr_gen
  import laplace_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CRD_W  = DEF_CRD_W
) (
  input  logic [CRD_W-1:0]  row,
  input  logic [CRD_W-1:0]  col,
  input  logic [2:0]        k,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    base = ADDR_W'(row) * STRIDE + ADDR_W'(col);
    case (k)
      K_B:     offset = ONE;
      K_D:     offset = STRIDE;
      K_E:     offset = STRIDE + ONE;
      K_F:     offset = STRIDE + TWO;
      K_H:     offset = (STRIDE << 1) + ONE;
      default: offset = '0;
    endcase
    addr = base + offset;
  end

endmodule

// File: rtl/laplace_scan_ctrl.sv
// Raster-scan sequencer: fetches each 5-point cross from image RAM, feeds the filter, hands results downstream.
module laplace_scan_ctrl
  import laplace_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CRD_W  = DEF_CRD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        b,
  output logic [7:0]        d,
  output logic [7:0]        e,
  output logic [7:0]        f,
  output logic [7:0]        h,
  input  logic [7:0]        s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [CRD_W-1:0]  out_row,
  output logic [CRD_W-1:0]  out_col
);

  localparam logic [CRD_W-1:0] LAST_ROW = CRD_W'(IMG_H - 3);
  localparam logic [CRD_W-1:0] LAST_COL = CRD_W'(IMG_W - 3);

  state_t            state;
  logic [2:0]        k;
  logic [2:0]        cap_k;
  logic              cap_valid;
  logic [CRD_W-1:0]  row;
  logic [CRD_W-1:0]  col;
  logic [ADDR_W-1:0] gen_addr;

  laplace_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W),
    .CRD_W  (CRD_W)
  ) u_addr_gen (
    .row  (row),
    .col  (col),
    .k    (k),
    .addr (gen_addr)
  );

  assign rd_addr = rd_en ? gen_addr : '0;

  // cap_valid/cap_k trail the read strobe by one cycle to match the RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= K_B;
      cap_k     <= K_B;
      cap_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      b         <= '0;
      d         <= '0;
      e         <= '0;
      f         <= '0;
      h         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      cap_valid <= rd_en;
      cap_k     <= k;
      if (cap_valid) begin
        case (cap_k)
          K_B:     b <= rd_data;
          K_D:     d <= rd_data;
          K_E:     e <= rd_data;
          K_F:     f <= rd_data;
          K_H:     h <= rd_data;
          default: ;
        endcase
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
            rd_en <= 1'b1;
            row   <= '0;
            col   <= '0;
            k     <= K_B;
          end
        end
        FETCH: begin
          if (k == K_H) begin
            state <= LAST;
            rd_en <= 1'b0;
            k     <= K_B;
          end else begin
            k <= k + 3'd1;
          end
        end
        LAST: state <= CALC;
        CALC: begin
          out_data  <= s;
          out_row   <= row;
          out_col   <= col;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == LAST_ROW && col == LAST_COL) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              state <= FETCH;
              rd_en <= 1'b1;
              k     <= K_B;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laplace_scan_ctrl.sv
// Bench for laplace_scan_ctrl: a 512x512 instance with a pass-through filter stub and a 5x4 instance with random image data.
module tb_laplace_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Large instance: img[i] = i mod 256, filter stub s = e.
  logic        rst_n0, start0, busy0, done0, rd_en0, out_valid0, out_ready0;
  logic [17:0] rd_addr0;
  logic [7:0]  rd_data0, b0, d0, e0, f0, h0, s0, out_data0;
  logic [8:0]  out_row0, out_col0;

  // Small instance: 5 wide, 4 high, random image, arbitrary stub filter.
  logic        rst_n1, start1, busy1, done1, rd_en1, out_valid1, out_ready1;
  logic [4:0]  rd_addr1;
  logic [7:0]  rd_data1, b1, d1, e1, f1, h1, s1, out_data1;
  logic [2:0]  out_row1, out_col1;
  logic [7:0]  img1 [20];

  laplace_scan_ctrl #(.IMG_W(512), .IMG_H(512), .ADDR_W(18), .CRD_W(9)) u0 (
    .clk(clk), .rst_n(rst_n0), .start(start0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .b(b0), .d(d0), .e(e0), .f(f0), .h(h0), .s(s0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_row(out_row0), .out_col(out_col0));

  laplace_scan_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(5), .CRD_W(3)) u1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .b(b1), .d(d1), .e(e1), .f(f1), .h(h1), .s(s1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_row(out_row1), .out_col(out_col1));

  function automatic logic [7:0] filt(input logic [7:0] nb, nd, ne, nf, nh);
    return 8'(ne + (nb ^ nh) - (nd >> 1) + nf);
  endfunction

  assign s0 = e0;
  assign s1 = filt(b1, d1, e1, f1, h1);

  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= rd_addr0[7:0];
    if (rd_en1) rd_data1 <= (rd_addr1 < 5'd20) ? img1[rd_addr1] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBigIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy0), 32'd0);
    checkOutput({tag, "_done"}, 32'(done0), 32'd0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en0), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr0), 32'd0);
    checkOutput({tag, "_window"}, {b0, d0, e0, f0}, 32'd0);
    checkOutput({tag, "_h"}, 32'(h0), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data0), 32'd0);
    checkOutput({tag, "_out_rc"}, 32'({out_row0, out_col0}), 32'd0);
  endtask

  // Runs one full small scan with out_ready high; optionally pulses start while busy.
  task automatic runSmallScan(input bit perturb, input string tag);
    int addrs[$];
    int outs[$];
    int done_n = 0;
    int done_rel = 0;
    int p = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int rel = 1; rel <= 60; rel++) begin
      start1 = (perturb && rel <= 48) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (rd_en1) addrs.push_back(int'(rd_addr1));
      if (out_valid1 && out_ready1) outs.push_back(int'({out_row1, out_col1, out_data1}));
      if (done1) begin
        done_n++;
        done_rel = rel;
      end
      if (rel == 50) checkOutput({tag, "_busy_after_done"}, 32'(busy1), 32'd0);
      tick();
    end
    start1 = 1'b0;
    checkOutput({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    checkOutput({tag, "_done_cycle"}, 32'(done_rel), 32'd49);
    checkOutput({tag, "_n_outputs"}, 32'(outs.size()), 32'd6);
    checkOutput({tag, "_n_reads"}, 32'(addrs.size()), 32'd30);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        int base = r * 5 + c;
        int ea[5];
        ea = '{base + 1, base + 5, base + 6, base + 7, base + 11};
        for (int kk = 0; kk < 5; kk++)
          if (p * 5 + kk < addrs.size())
            checkOutput({tag, "_read_addr"}, 32'(addrs[p * 5 + kk]), 32'(ea[kk]));
        if (p < outs.size())
          checkOutput({tag, "_result"}, 32'(outs[p]),
                      32'({3'(r), 3'(c), filt(img1[ea[0]], img1[ea[1]], img1[ea[2]], img1[ea[3]], img1[ea[4]])}));
        p++;
      end
    end
  endtask

  initial begin
    int exp_p;
    bit seen;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [17:0] first_addrs[5];

    rst_n0 = 1'b0; start0 = 1'b0; out_ready0 = 1'b0;
    rst_n1 = 1'b0; start1 = 1'b0; out_ready1 = 1'b1;
    for (int i = 0; i < 20; i++) img1[i] = 8'($urandom);
    tick();
    tick();
    checkBigIdle("reset");
    checkOutput("small_reset_busy", 32'({busy1, rd_en1, out_valid1, done1}), 32'd0);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    tick();

    // First pixel: read sequence and first result latency.
    first_addrs = '{18'd1, 18'd512, 18'd513, 18'd514, 18'd1025};
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("first_rd_en", 32'(rd_en0), 32'd1);
      checkOutput("first_rd_addr", 32'(rd_addr0), 32'(first_addrs[i]));
      checkOutput("first_busy", 32'(busy0), 32'd1);
      tick();
    end
    checkOutput("last_rd_en", 32'(rd_en0), 32'd0);
    tick();
    checkOutput("calc_out_valid", 32'(out_valid0), 32'd0);
    tick();
    checkOutput("first_out_valid", 32'(out_valid0), 32'd1);
    checkOutput("first_out_data", 32'(out_data0), 32'h01);
    checkOutput("first_out_rc", 32'({out_row0, out_col0}), 32'd0);

    // Backpressure for ten cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_valid", 32'(out_valid0), 32'd1);
      checkOutput("stall_data", 32'(out_data0), 32'h01);
      checkOutput("stall_rd_en", 32'(rd_en0), 32'd0);
    end
    out_ready0 = 1'b1;
    tick();
    checkOutput("accept_rd_en", 32'(rd_en0), 32'd1);
    checkOutput("accept_rd_addr", 32'(rd_addr0), 32'd2);

    // Random stalls and stray start pulses through the end of row 0.
    exp_p = 1;
    seen = 1'b0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int i = 0; i < 6000 && !seen; i++) begin
      out_ready0 = ($urandom_range(0, 3) != 0);
      start0 = busy0 && ($urandom_range(0, 7) == 0);
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid0), 32'd1);
        checkOutput("hold_data", 32'(out_data0), 32'(prev_data));
        checkOutput("hold_rd_en", 32'(rd_en0), 32'd0);
      end
      prev_stall = out_valid0 && !out_ready0;
      prev_data = out_data0;
      if (out_valid0 && out_ready0) begin
        checkOutput("scan_row", 32'(out_row0), 32'(exp_p / 510));
        checkOutput("scan_col", 32'(out_col0), 32'(exp_p % 510));
        checkOutput("scan_data", 32'(out_data0), 32'(((exp_p / 510) * 512 + (exp_p % 510) + 513) % 256));
        if (exp_p == 509) seen = 1'b1;
        exp_p++;
      end
      tick();
    end
    start0 = 1'b0;
    out_ready0 = 1'b0;
    checkOutput("row0_end_reached", 32'(seen), 32'd1);
    checkOutput("wrap_rd_en", 32'(rd_en0), 32'd1);
    checkOutput("wrap_rd_addr", 32'(rd_addr0), 32'd513);
    for (int i = 0; i < 20 && !out_valid0; i++) tick();
    checkOutput("wrap_out_valid", 32'(out_valid0), 32'd1);
    checkOutput("wrap_out_row", 32'(out_row0), 32'd1);
    checkOutput("wrap_out_col", 32'(out_col0), 32'd0);
    checkOutput("wrap_out_data", 32'(out_data0), 32'd1);

    // Reset in the middle of a fetch aborts the scan.
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
    tick();
    checkOutput("pre_abort_rd_en", 32'(rd_en0), 32'd1);
    rst_n0 = 1'b0;
    tick();
    tick();
    checkBigIdle("abort");
    rst_n0 = 1'b1;
    tick();
    checkBigIdle("post_abort");
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checkOutput("restart_rd_en", 32'(rd_en0), 32'd1);
    checkOutput("restart_rd_addr", 32'(rd_addr0), 32'd1);

    // Complete scans of the small image, clean and with stray start pulses.
    runSmallScan(1'b0, "small_clean");
    runSmallScan(1'b1, "small_perturbed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/laplace_scan_ctrl.md
# laplace_scan_ctrl

Sequencer that drives the 5-point approximate Laplacian filter (`laplace9_aprox_2`, inputs b/d/e/f/h, output s) across a stored 8-bit greyscale image. It fetches each cross-shaped neighbourhood from a single-port, 1-cycle-latency image memory and presents it to the filter. It captures the result and hands it downstream with a valid/ready handshake, scanning the (IMG_H−2)×(IMG_W−2) valid output region in raster order. It sits between the image RAM and the result sink and replaces the testbench-driven scan.

## Interface
- IMG_W, 512, image width in pixels (row stride in memory)
- IMG_H, 512, image height in pixels
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- CRD_W, 9, width of output coordinates; must satisfy 2^CRD_W ≥ max(IMG_W, IMG_H)−2
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a full-image scan; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output handshake
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  8  read data, valid the cycle after rd_en
- b, d, e, f, h  out  8 each  window registers to filter (north, west, centre, east, south)
- s  in  8  filter result (combinational from b..h)
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_data  out  8  latched filter result
- out_row, out_col  out  CRD_W each  output-image coordinates of out_data

## Operation
- Counters row ∈ [0, IMG_H−3], col ∈ [0, IMG_W−3]; base = row·IMG_W + col.
- Read order and addresses, k=0..4:
  - B = base+1
  - D = base+IMG_W
  - E = base+IMG_W+1
  - F = base+IMG_W+2
  - H = base+2·IMG_W+1
- rd_data from read k is written into the matching window register the following cycle.
- FSM:
  - IDLE: start=1 → FETCH, row=col=0, k=0.
  - FETCH: rd_en=1, rd_addr per k, k++. After k=4 → LAST.
  - LAST: capture h, rd_en=0 → CALC.
  - CALC: out_data←s, out_row←row, out_col←col → OUT.
  - OUT: out_valid=1. On out_valid&out_ready:
    - last pixel (row=IMG_H−3, col=IMG_W−3) → DONE
    - otherwise advance: col++; when col=IMG_W−3, col←0 and row++. Then → FETCH, k=0.
  - DONE: done=1 → IDLE.
- Address arithmetic is unsigned at ADDR_W bits. Parameter legality guarantees no overflow.
- start while busy is ignored. start held high in IDLE after DONE starts a new scan.
- The window registers hold their values outside FETCH/LAST; out_data/out_row/out_col hold outside CALC.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, k/row/col=0. All outputs 0: busy, done, rd_en, rd_addr, b..h, out_valid, out_data, out_row, out_col.
- Reset mid-scan aborts immediately; no done pulse.
- start sampled at edge N:
  - rd_en high cycles N+1..N+5
  - LAST N+6, CALC N+7, out_valid from N+8
- Per pixel: 8 cycles with out_ready held high, plus one cycle per stall.
- Under out_valid=1 and out_ready=0: out_valid, out_data, out_row and out_col are held stable; no reads are issued.
- A handshake on the first OUT cycle is legal.
- done is asserted the cycle after the final handshake. busy is 1 in DONE and 0 the cycle after.
- Total scan with no stalls: 8·(IMG_H−2)·(IMG_W−2) + 2 cycles, start to done inclusive.

## Structure
- Shared package `laplace_pkg`:
  - state enum (IDLE, FETCH, LAST, CALC, OUT, DONE)
  - default IMG_W/IMG_H/ADDR_W/CRD_W constants
  - neighbour index constants K_B..K_H
- One sub-module, `laplace_addr_gen`: combinational rd_addr from row, col, k. The FSM, counters, window registers and output registers stay in the top.
- The filter is not instantiated inside. The bench and the top level connect b..h/s to `laplace9_aprox_2`.

## Test plan
- Reset: hold rst_n=0 two cycles mid-FETCH → next cycle all outputs 0, busy=0. start then behaves as from IDLE.
- First pixel, memory img[i]=i mod 256, IMG_W=512, stub filter s=e:
  - rd_addr 1, 512, 513, 514, 1025 on cycles N+1..N+5
  - out_valid at N+8 with out_data=8'h01, out_row=0, out_col=0
- Backpressure: out_ready=0 for 10 cycles → out_valid stays 1, out_data unchanged, rd_en=0 throughout. Accept → next rd_en one cycle later.
- Row wrap: after handshake of (row 0, col 509), the next reads start at 513, and out_row=1, out_col=0.
- Completion with IMG_W=5, IMG_H=4, out_ready=1:
  - exactly 6 outputs in raster order (0,0)…(1,2)
  - done single pulse at cycle N+49
  - busy=0 at N+50
- start pulsed during FETCH/OUT → ignored; output count and addresses identical to an unperturbed run.
